// File: rtl/d_ext_pipe.sv
// Decode-stage immediate extender (zero/sign/upper/branch) with a 2-entry skid FIFO.
// Optional accepted-transfer counter enabled by `D_EXT_PIPE_CNT_EN.
module d_ext_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       ext_cnt
);

  localparam int unsigned PAD_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] ext_c;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        cnt_q;
  logic              acc_c;
  logic              iss_c;

  // Extension happens before storage so the FIFO holds final values.
  always_comb begin
    ext_c = '0;
    case (in_mode)
      2'd0:    ext_c = {{PAD_W{1'b0}}, in_imm};
      2'd1:    ext_c = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
      2'd2:    ext_c = {in_imm, {PAD_W{1'b0}}};
      default: ext_c = {{(PAD_W-2){in_imm[IMM_W-1]}}, in_imm, 2'b00};
    endcase
  end

  // Handshake flags decode only the occupancy register.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? head_q : '0;
  assign acc_c     = in_valid & in_ready;
  assign iss_c     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      case ({acc_c, iss_c})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= ext_c;
            cnt_q  <= 2'd1;
          end else begin
            tail_q <= ext_c;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        // Accept and issue together only happens at one entry: replace the head.
        2'b11:   head_q <= ext_c;
        default: ;
      endcase
    end
  end

`ifdef D_EXT_PIPE_CNT_EN
  logic [31:0] ext_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_cnt_q <= '0;
    end else if (acc_c && !flush) begin
      ext_cnt_q <= ext_cnt_q + 32'd1;
    end
  end

  assign ext_cnt = ext_cnt_q;
`else
  assign ext_cnt = '0;
`endif

endmodule

// File: doc/d_ext_pipe.md
# d_ext_pipe

Parametrised, buffered immediate extender for the decode stage. It accepts an immediate field plus an extension mode through a valid/ready handshake, and computes zero-, sign-, upper- or branch-offset extension. Results are held in a 2-entry FIFO skid buffer so the E-stage can apply back-pressure without losing data. A synchronous flush drops everything in flight when a branch or exception redirects the pipeline.

## Interface
- `IMM_W`, default 16: immediate field width.
- `DATA_W`, default 32: extended result width. Must satisfy `DATA_W >= IMM_W + 2`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: upstream offers an immediate.
- `in_ready` output 1: block can accept an immediate this cycle.
- `in_imm` input IMM_W: raw immediate field.
- `in_mode` input 2: extension mode; encoding under Operation.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes the head entry.
- `out_data` output DATA_W: extended value at the head.
- `ext_cnt` output 32: accepted-transfer counter (see Configuration).

## Operation
- Extension is computed combinationally on input and stored already extended.
- Modes:
  - 0 = zero: `{0, imm}`.
  - 1 = sign: imm[IMM_W-1] replicated into the upper bits.
  - 2 = upper: `imm << (DATA_W-IMM_W)`, low bits 0.
  - 3 = branch offset: sign-extend, then `<< 2`; the top 2 bits of the sign-extended value are discarded.
- Storage is a 2-entry FIFO: head, tail, and a 2-bit occupancy `cnt` in {0,1,2}.
- Accept and issue:
  - Accept = `in_valid & in_ready`.
  - Issue = `out_valid & out_ready`.
  - `in_ready = (cnt != 2)`.
  - `out_valid = (cnt != 0)`.
  - `out_data` = head entry data; 0 when `cnt == 0`.
- State transitions (cnt):
  - 0: accept → 1.
  - 1: accept only → 2; issue only → 0; accept and issue together → stays 1, new entry becomes head.
  - 2: issue → 1, tail moves to head. Accept is impossible because `in_ready = 0`.
- Flush:
  - `cnt` → 0 on the next edge.
  - Any accept or issue in the same cycle is discarded; flush has priority.
  - `ext_cnt` does not count a transfer accepted during a flush cycle.
- FIFO order is strict; no entry is ever reordered or duplicated.

## Timing
- Latency: an immediate accepted at edge N appears on `out_data` with `out_valid = 1` after edge N (visible in cycle N+1).
- Throughput: 1 per cycle while `out_ready = 1`.
- Full back-pressure: `in_ready` drops in the cycle after the second entry is stored. It rises in the cycle after an issue from full.
- `in_ready` and `out_valid` depend only on registers. No combinational path exists from `out_ready` to `in_ready`.
- Reset, asynchronous and active-low: `cnt` = 0, entries = 0, `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `ext_cnt` = 0.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Upstream holds `in_imm`/`in_mode` stable only for the accepting cycle; no stability is required beyond it.
- Downstream may deassert `out_ready` at any time. The head entry is held unchanged until issued or flushed.

## Configuration
- Macro: `D_EXT_PIPE_CNT_EN`.
- Defined: `ext_cnt` increments by 1 on every accept that is not flushed. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Undefined: the counter register is not built. `ext_cnt` is tied to 0, and ports stay identical.

## Test plan
- Modes, with IMM_W=16 and DATA_W=32, `out_ready`=1, `in_imm`=16'h8001:
  - mode 0 → 32'h00008001.
  - mode 1 → 32'hFFFF8001.
  - mode 2 → 32'h80010000.
  - mode 3 → 32'hFFFE0004.
  - Each result arrives one cycle after acceptance.
- Back-pressure: `out_ready`=0, push 16'h0001 then 16'h0002 (mode 0).
  - `in_ready`=0 from the third cycle.
  - A third offer of 16'h0003 is held.
  - Raising `out_ready` issues 1, 2, 3 in order with no loss.
- Simultaneous push/pop at `cnt`=1: `cnt` stays 1 and `out_data` becomes the new value on the next cycle; repeat 100 random values, and the outputs equal the inputs in order.
- Flush: with 2 entries held, assert `flush` together with `in_valid`. Next cycle `out_valid`=0 and `in_ready`=1. `ext_cnt` excludes the flushed-cycle offer.
- Async reset mid-stream: drop `reset` between edges while `cnt`=2. Outputs go to reset values before the next `clk` edge. After release, normal operation resumes.
- Counter: with `D_EXT_PIPE_CNT_EN` defined, 5 accepts give `ext_cnt`=5. Undefined, `ext_cnt`=0 throughout.
